arp_reply_ctrl: RTL
===================

Name: arp_reply_ctrl

Overview:
Sequencer between the ARP decoder and the shared MAC transmit path. On each ARP request the decoder reports cleanly, it checks the target IP against the local address and latches the sender fields. It then requests the TX arbiter, waits for a grant, and streams a 42-byte Ethernet+ARP reply byte-serially with a valid/ready handshake. It also keeps reply and drop statistics.

Parameters:
GNT_TIMEOUT, 1024, cycles to wait in REQ for tx_gnt before abandoning the reply (≥2)
CNT_W, 16, width of reply_cnt

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
en  in  1  block enable; 0 = ignore new decoder results, an in-flight reply still completes
local_mac  in  48  own MAC address, quasi-static
local_ip  in  32  own IPv4 address, quasi-static
dec_sha  in  48  decoder sender hardware address
dec_spa  in  32  decoder sender protocol address
dec_tpa  in  32  decoder target protocol address
dec_done  in  1  one-cycle pulse: decoder fields valid
dec_err  in  1  decoder error flag, qualifies dec_done
tx_req  out  1  request to TX arbiter
tx_gnt  in  1  grant from TX arbiter, held for whole frame once given
tx_valid  out  1  tx_data valid
tx_data  out  8  reply byte
tx_last  out  1  marks final byte (index 41)
tx_ready  in  1  downstream accepts byte
busy  out  1  state != IDLE
reply_cnt  out  CNT_W  replies fully sent, wraps
drop_cnt  out  8  matching requests lost (busy or timeout), saturates at 255

Behaviour:
- Reset (rst=0, async): state IDLE; tx_req, tx_valid, tx_last, busy = 0; tx_data = 0; reply_cnt, drop_cnt = 0; latched sha/spa = 0; byte index and timer = 0.
- Accept condition: dec_done && !dec_err && en && dec_tpa == local_ip.
- Condition not met (dec_err=1, tpa mismatch, or en=0): no action, no count.
- IDLE: on accept, latch dec_sha and dec_spa, go to REQ next cycle, assert tx_req. Latency from dec_done to tx_req is 1 cycle.
- REQ: hold tx_req=1; the timer counts cycles.
  - tx_gnt=1: go to SEND, index=0. tx_valid rises the cycle after grant is seen.
  - Timer reaches GNT_TIMEOUT-1 without grant: drop tx_req, drop_cnt+1, return to IDLE.
- SEND: tx_req stays 1. tx_valid=1 and tx_data=byte[index].
  - Data is held stable while tx_ready=0.
  - A transfer occurs when tx_valid && tx_ready; index then increments.
  - tx_last=1 only while index==41.
  - On transfer of index 41: next cycle tx_valid, tx_last and tx_req = 0, reply_cnt+1, state IDLE.
- Frame bytes (multi-byte fields MSB first):
  - 0-5: latched sha
  - 6-11: local_mac
  - 12-13: 08 06
  - 14-15: 00 01
  - 16-17: 08 00
  - 18: 06
  - 19: 04
  - 20-21: 00 02
  - 22-27: local_mac
  - 28-31: local_ip
  - 32-37: latched sha
  - 38-41: latched spa
- Accept while busy (REQ or SEND): request dropped, drop_cnt+1 (saturate at 255), latched fields unchanged.
- Accept in the same cycle the final byte transfers: counts as busy → dropped.
- tx_gnt is ignored outside REQ. Deassertion mid-SEND is an arbiter contract violation; the frame continues.
- en deasserted mid-frame: the frame completes.
- Async reset mid-frame: immediate return to reset values; the partial frame is abandoned.

Test Plan:
- local_ip=C0A80002, local_mac=02:00:00:00:00:01; dec_done with tpa=C0A80002, sha=AABBCCDDEEFF, spa=C0A80001; grant 3 cycles after tx_req, tx_ready=1 → 42 bytes exactly as the field list, tx_last on byte 41 only, reply_cnt=1, tx_req low the cycle after the last transfer.
- Same request with tx_ready toggled pseudo-randomly → identical byte sequence, tx_data stable during stalls, no duplicated or skipped bytes.
- dec_done with tpa=C0A80003, or dec_err=1, or en=0 → tx_req stays 0, reply_cnt=0, drop_cnt=0.
- Second matching dec_done during SEND → first frame unchanged, drop_cnt=1, no second frame; 300 such drops → drop_cnt=255.
- GNT_TIMEOUT=8, tx_gnt held low → tx_req high for exactly 8 cycles, then IDLE, drop_cnt=1, tx_valid never asserted.
- rst pulled low at byte 20 → all outputs 0 immediately. After release, a new request produces a full 42-byte frame starting at byte 0.

Source files
------------

// File: rtl/arp_reply_ctrl_if.sv
// Decoder result bundle and byte-serial TX path shared by the ARP reply sequencer.
// master = the sequencer (consumes decoder results, drives the TX stream);
// slave  = the surrounding decoder / arbiter / MAC side.
interface arp_reply_ctrl_if;
  logic [47:0] dec_sha;
  logic [31:0] dec_spa;
  logic [31:0] dec_tpa;
  logic        dec_done;
  logic        dec_err;

  logic        tx_req;
  logic        tx_gnt;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        tx_ready;

  modport master (
    input  dec_sha, dec_spa, dec_tpa, dec_done, dec_err,
    output tx_req,
    input  tx_gnt,
    output tx_valid, tx_data, tx_last,
    input  tx_ready
  );

  modport slave (
    output dec_sha, dec_spa, dec_tpa, dec_done, dec_err,
    input  tx_req,
    output tx_gnt,
    input  tx_valid, tx_data, tx_last,
    output tx_ready
  );
endinterface

// File: rtl/arp_reply_ctrl.sv
// ARP reply sequencer: matches decoded requests, arbitrates for TX, streams a 42-byte reply.
// Latency: tx_req 1 cycle after an accepted dec_done; first byte valid 1 cycle after grant.
// Backpressure: tx_data/tx_last held while tx_ready=0; requests arriving while busy are dropped.
module arp_reply_ctrl #(
  parameter int GNT_TIMEOUT = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [47:0]          local_mac,
  input  logic [31:0]          local_ip,
  arp_reply_ctrl_if.master     bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     reply_cnt,
  output logic [7:0]           drop_cnt
);

  // GNT_TIMEOUT is at least 2, so the timer is always at least one bit wide.
  localparam int TMR_W    = $clog2(GNT_TIMEOUT);
  localparam int LAST_IDX = 41;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [47:0]        sha_q, sha_d;
  logic [31:0]        spa_q, spa_d;
  logic [5:0]         idx_q, idx_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   reply_cnt_q, reply_cnt_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  logic               accept;
  logic               xfer;
  logic               last_byte;
  logic [1:0]         drop_inc;
  logic [8:0]         drop_sum;
  logic [335:0]       frame;
  logic [8:0]         bit_off;

  // A request is only ours if it decoded cleanly and targets our IP.
  assign accept = bus.dec_done && !bus.dec_err && en && (bus.dec_tpa == local_ip);

  // Whole reply laid out MSB-first: byte 0 sits in frame[335:328].
  assign frame = {sha_q, local_mac,
                  16'h0806,             // ethertype ARP
                  16'h0001,             // htype Ethernet
                  16'h0800,             // ptype IPv4
                  8'h06, 8'h04,         // hlen, plen
                  16'h0002,             // opcode reply
                  local_mac, local_ip,
                  sha_q, spa_q};

  assign last_byte = (idx_q == 6'(LAST_IDX));
  // idx_q never exceeds LAST_IDX, so the subtraction cannot wrap.
  assign bit_off   = {6'(LAST_IDX) - idx_q, 3'b000};
  assign xfer      = (state_q == S_SEND) && bus.tx_ready;

  // Outputs are decoded straight from registered state, so they are glitch-free
  // and fall to zero the instant reset asserts.
  always_comb begin
    bus.tx_req   = (state_q != S_IDLE);
    bus.tx_valid = (state_q == S_SEND);
    bus.tx_last  = (state_q == S_SEND) && last_byte;
    bus.tx_data  = (state_q == S_SEND) ? frame[bit_off +: 8] : 8'h00;
  end

  assign busy      = (state_q != S_IDLE);
  assign reply_cnt = reply_cnt_q;
  assign drop_cnt  = drop_cnt_q;

  // Next-state, field latching, frame indexing, grant timer and statistics.
  always_comb begin
    state_d     = state_q;
    sha_d       = sha_q;
    spa_d       = spa_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    reply_cnt_d = reply_cnt_q;
    drop_inc    = 2'd0;

    // Any match while a reply is outstanding (including the final-byte cycle) is lost.
    if (accept && (state_q != S_IDLE)) begin
      drop_inc = drop_inc + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sha_d   = bus.dec_sha;
          spa_d   = bus.dec_spa;
          tmr_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Grant wins over a timeout landing in the same cycle.
        if (bus.tx_gnt) begin
          idx_d   = '0;
          tmr_d   = '0;
          state_d = S_SEND;
        end else if (tmr_q == TMR_W'(GNT_TIMEOUT - 1)) begin
          tmr_d    = '0;
          drop_inc = drop_inc + 2'd1;
          state_d  = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_SEND: begin
        // Grant is not re-checked here: once the frame starts it runs to the end.
        if (xfer) begin
          if (last_byte) begin
            idx_d       = '0;
            reply_cnt_d = reply_cnt_q + 1'b1;
            state_d     = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    drop_sum   = {1'b0, drop_cnt_q} + {7'd0, drop_inc};
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // State and datapath registers; reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sha_q       <= '0;
      spa_q       <= '0;
      idx_q       <= '0;
      tmr_q       <= '0;
      reply_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sha_q       <= sha_d;
      spa_q       <= spa_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      reply_cnt_q <= reply_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule
